// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared types and constants for the issue-stage hazard controller.
package issue_hazard_ctrl_pkg;

  localparam int unsigned OPND_W = 8;
  localparam int unsigned SCNT_W = 16;

  localparam logic [OPND_W-1:0] OP_NOP = 8'd0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Instruction payload carried from decode to execute
  typedef struct packed {
    logic [OPND_W-1:0] op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [OPND_W-1:0] c;
  } instr_t;

  localparam instr_t INSTR_BUBBLE = '{op: OP_NOP, a: '0, b: '0, c: '0};

endpackage

// File: rtl/issue_hazard_ctrl_scoreboard.sv
// Register scoreboard: pending-write bits, same-cycle writeback bypass and
// outstanding-write counter.
module hazard_scoreboard
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW       = 4,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned ZERO_REG     = 1,
  parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] a_i,
  input  logic [REG_AW-1:0] b_i,
  input  logic [REG_AW-1:0] c_i,
  input  logic              wr_i,
  input  logic              rd_b_i,
  input  logic              rd_c_i,
  input  logic              issue_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  output logic              hazard_c_o,
  output logic [CNT_W-1:0]  inflight_o
);

  localparam int unsigned NREGS = 2 ** REG_AW;

  logic [NREGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  logic             wb_hit;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] pend_eff;
  logic [CNT_W-1:0] cnt_eff;
  logic             raw, waw, full;
  logic             dst_is_zero;
  logic             do_set;
  logic [NREGS-1:0] set_mask;

  // Hazard lookup with a retiring writeback treated as already complete
  always_comb begin
    wb_hit     = wb_valid_i & pend_q[wb_addr_i];
    clr_mask   = wb_hit ? (NREGS'(1) << wb_addr_i) : '0;
    pend_eff   = pend_q & ~clr_mask;
    cnt_eff    = inflight_q - CNT_W'(wb_hit);
    raw        = (rd_b_i & pend_eff[b_i]) | (rd_c_i & pend_eff[c_i]);
    waw        = wr_i & pend_eff[a_i];
    full       = wr_i & (cnt_eff == CNT_W'(MAX_INFLIGHT));
    hazard_c_o = raw | waw | full;
  end

  // Next scoreboard: set on issue overrides a same-cycle clear of that register
  always_comb begin
    dst_is_zero = (ZERO_REG != 0) && (a_i == '0);
    do_set      = issue_i & wr_i & ~dst_is_zero;
    set_mask    = do_set ? (NREGS'(1) << a_i) : '0;
    pend_d      = pend_eff | set_mask;
    inflight_d  = cnt_eff + CNT_W'(do_set);
  end

  // Scoreboard state
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      inflight_q <= '0;
    end else begin
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
    end
  end

  assign inflight_o = inflight_q;

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue-stage controller: stalls decode on RAW/WAW/capacity hazards, injects
// bubbles downstream and holds a timed flush window after a branch redirect.
module issue_hazard_ctrl
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW       = 4,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned ZERO_REG     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 id_valid,
  input  logic [OPND_W-1:0]                    id_op,
  input  logic [OPND_W-1:0]                    id_a,
  input  logic [OPND_W-1:0]                    id_b,
  input  logic [OPND_W-1:0]                    id_c,
  input  logic                                 id_wr,
  input  logic                                 id_rd_b,
  input  logic                                 id_rd_c,
  input  logic                                 wb_valid,
  input  logic [OPND_W-1:0]                    wb_addr,
  input  logic                                 flush_req,
  output logic                                 stall,
  output logic                                 iss_valid,
  output logic [OPND_W-1:0]                    iss_op,
  output logic [OPND_W-1:0]                    iss_a,
  output logic [OPND_W-1:0]                    iss_b,
  output logic [OPND_W-1:0]                    iss_c,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
  output logic [SCNT_W-1:0]                    stall_cnt
);

  localparam int unsigned CNT_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                iss_valid_q, iss_valid_d;
  instr_t              iss_q, iss_d;
  logic [SCNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic                hazard_c;
  logic                issue_c;
  logic                unused_wb_hi;

  // Upper address bits only matter downstream, not for register lookup
  assign unused_wb_hi = ^wb_addr[OPND_W-1:REG_AW];

  hazard_scoreboard #(
    .REG_AW       (REG_AW),
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .ZERO_REG     (ZERO_REG),
    .CNT_W        (CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .a_i        (id_a[REG_AW-1:0]),
    .b_i        (id_b[REG_AW-1:0]),
    .c_i        (id_c[REG_AW-1:0]),
    .wr_i       (id_wr),
    .rd_b_i     (id_rd_b),
    .rd_c_i     (id_rd_c),
    .issue_i    (issue_c),
    .wb_valid_i (wb_valid),
    .wb_addr_i  (wb_addr[REG_AW-1:0]),
    .hazard_c_o (hazard_c),
    .inflight_o (inflight)
  );

  // Flush sequencing, stall decision and next issue-register contents
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall       = 1'b0;
    issue_c     = 1'b0;
    iss_valid_d = 1'b0;
    iss_d       = INSTR_BUBBLE;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_RELOAD;
        end
      end
      ST_FLUSH: begin
        if (flush_req) begin
          fcnt_d = FCNT_RELOAD;
        end else if (fcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end
    endcase

    stall   = rst | (state_q == ST_FLUSH) | flush_req | (id_valid & hazard_c);
    issue_c = id_valid & ~stall;

    if (issue_c) begin
      iss_valid_d = 1'b1;
      iss_d       = '{op: id_op, a: id_a, b: id_b, c: id_c};
    end

    if (stall && (stall_cnt_q != {SCNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + SCNT_W'(1);
    end
  end

  // State, issue register and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      iss_valid_q <= 1'b0;
      iss_q       <= INSTR_BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_op    = iss_q.op;
  assign iss_a     = iss_q.a;
  assign iss_b     = iss_q.b;
  assign iss_c     = iss_q.c;
  assign stall_cnt = stall_cnt_q;

endmodule
